// File: rtl/inst_queue.sv
// inst_queue: two-wide IF->ID instruction buffer that keeps branches together with their delay slots.
//   clk, resetn       : clock and asynchronous active-low reset
//   flush             : discard every buffered entry
//   in_valid/ins/pc/exc, in_ready : fetch side, up to two instructions per cycle
//   out_valid/ins/pc/exc/rs/rt/rd/br, out_accept : decode side, lane0 is the oldest
module inst_queue #(
  parameter int DEPTH = 8,
  parameter int EXC_W = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               flush,
  input  logic [1:0]         in_valid,
  input  logic [63:0]        in_ins,
  input  logic [63:0]        in_pc,
  input  logic [2*EXC_W-1:0] in_exc,
  output logic               in_ready,
  output logic [1:0]         out_valid,
  output logic [63:0]        out_ins,
  output logic [63:0]        out_pc,
  output logic [2*EXC_W-1:0] out_exc,
  output logic [13:0]        out_rs,
  output logic [13:0]        out_rt,
  output logic [13:0]        out_rd,
  output logic [1:0]         out_br,
  input  logic               out_accept
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0]    ins_q [DEPTH];
  logic [31:0]    pc_q  [DEPTH];
  logic [EXC_W-1:0] exc_q [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr, wr1, rd1;
  logic [AW:0]    count, push_cnt, pop_cnt;
  logic           push, pop;
  logic [31:0]    h0, h1;
  function automatic logic is_br(input logic [31:0] i);
    logic [5:0] op;
    op = i[31:26];
    return op inside {6'b000001, 6'b000010, 6'b000011, 6'b000100, 6'b000101,
                      6'b000110, 6'b000111, 6'b010100} ||
           (op == 6'b000000 && (i[5:0] == 6'b001000 || i[5:0] == 6'b001001));
  endfunction
  assign wr1 = wr_ptr + 1'b1;
  assign rd1 = rd_ptr + 1'b1;
  assign in_ready = count <= (AW+1)'(DEPTH - 2);
  assign push = in_ready && in_valid[0] && !flush;
  assign pop = out_accept && !flush;
  assign push_cnt = push ? {{(AW-1){1'b0}}, in_valid[1], ~in_valid[1]} : '0;
  assign pop_cnt = pop ? {{(AW-1){1'b0}}, out_valid[1], out_valid[0] & ~out_valid[1]} : '0;
  assign h0 = ins_q[rd_ptr];
  assign h1 = ins_q[rd1];
  assign out_br = {is_br(h1), is_br(h0)};
  // A lone branch waits for its delay slot; a branch in lane1 is held back to lead the next group.
  assign out_valid = count == '0 ? 2'b00 :
                     count == (AW+1)'(1) ? (out_br[0] ? 2'b00 : 2'b01) :
                     out_br[0] ? 2'b11 : out_br[1] ? 2'b01 : 2'b11;
  assign out_ins = {h1, h0};
  assign out_pc = {pc_q[rd1], pc_q[rd_ptr]};
  assign out_exc = {exc_q[rd1], exc_q[rd_ptr]};
  assign out_rs = {2'b00, h1[25:21], 2'b00, h0[25:21]};
  assign out_rt = {2'b00, h1[20:16], 2'b00, h0[20:16]};
  assign out_rd = {2'b00, h1[15:11], 2'b00, h0[15:11]};
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ins_q[i] <= '0;
        pc_q[i] <= '0;
        exc_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        ins_q[wr_ptr] <= in_ins[31:0];
        pc_q[wr_ptr] <= in_pc[31:0];
        exc_q[wr_ptr] <= in_exc[EXC_W-1:0];
        if (in_valid[1]) begin
          ins_q[wr1] <= in_ins[63:32];
          pc_q[wr1] <= in_pc[63:32];
          exc_q[wr1] <= in_exc[2*EXC_W-1:EXC_W];
        end
      end
      wr_ptr <= wr_ptr + push_cnt[AW-1:0];
      rd_ptr <= rd_ptr + pop_cnt[AW-1:0];
      count <= count + push_cnt - pop_cnt;
    end
  end
endmodule
